// File: rtl/phys_free_list_if.sv
// Rename/retire-side bundle for the physical-register free list.
// The master side is rename plus retire; the slave side is the free list.
interface phys_free_list_if #(
    parameter int PTAG_W = 6
);
    logic              alloc_req_1;
    logic              alloc_req_2;
    logic [PTAG_W-1:0] alloc_tag_1;
    logic [PTAG_W-1:0] alloc_tag_2;
    logic              alloc_stall;
    logic              rt_flag_1;
    logic [PTAG_W-1:0] fp_i_1;
    logic              rt_flag_2;
    logic [PTAG_W-1:0] fp_i_2;
    logic [PTAG_W:0]   free_count;
    logic              ovf_err;
    logic              dup_err;

    modport master (
        output alloc_req_1, alloc_req_2, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2,
        input  alloc_tag_1, alloc_tag_2, alloc_stall, free_count, ovf_err, dup_err
    );

    modport slave (
        input  alloc_req_1, alloc_req_2, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2,
        output alloc_tag_1, alloc_tag_2, alloc_stall, free_count, ovf_err, dup_err
    );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical tags: two show-ahead allocations and two retire frees per cycle.
// Define FREELIST_CHECK_EN to add an in-list bitmap that drops and flags duplicate frees.
module phys_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PTAG_W    = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    phys_free_list_if.slave fl
);
    typedef logic [PTAG_W-1:0] ptag_t;
    typedef logic [PTAG_W:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(NUM_PREGS);
    localparam cnt_t CNT_INIT = cnt_t'(NUM_PREGS - NUM_AREGS);

    ptag_t mem [NUM_PREGS];
    ptag_t head;
    ptag_t tail;
    cnt_t  count;
    logic  ovf_q;

    logic [1:0] need;
    logic [1:0] pop_n;
    logic       stall;
    logic       nz_1, nz_2;
    logic       dup_1, dup_2;
    logic       room_1, room_2;
    logic       acc_1, acc_2;
    logic       ovf_1, ovf_2;

    // Stall is judged against the registered count only, so same-cycle frees never rescue it.
    assign need  = {1'b0, fl.alloc_req_1} + {1'b0, fl.alloc_req_2};
    assign stall = cnt_t'(need) > count;
    assign pop_n = stall ? 2'd0 : need;

    assign fl.alloc_tag_1 = mem[head];
    assign fl.alloc_tag_2 = fl.alloc_req_1 ? mem[head + ptag_t'(1)] : mem[head];
    assign fl.alloc_stall = stall;
    assign fl.free_count  = count;
    assign fl.ovf_err     = ovf_q;

    // Tag 0 is the hardwired zero register and is never returned to the list.
    assign nz_1 = fl.rt_flag_1 && (fl.fp_i_1 != '0);
    assign nz_2 = fl.rt_flag_2 && (fl.fp_i_2 != '0);

    // Slot 2 sees the count as it stands after slot 1's push.
    assign room_1 = count < CNT_FULL;
    assign room_2 = (count + cnt_t'(acc_1)) < CNT_FULL;
    assign acc_1  = nz_1 && !dup_1 && room_1;
    assign acc_2  = nz_2 && !dup_2 && room_2;
    assign ovf_1  = nz_1 && !dup_1 && !room_1;
    assign ovf_2  = nz_2 && !dup_2 && !room_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= ptag_t'(NUM_PREGS - NUM_AREGS);
            count <= CNT_INIT;
            ovf_q <= 1'b0;
            // NOTE: the storage array is reset on purpose -- its contents are the initial free tags.
            for (int i = 0; i < NUM_PREGS; i++) begin
                mem[i] <= (i < NUM_PREGS - NUM_AREGS) ? ptag_t'(NUM_AREGS + i) : '0;
            end
        end else begin
            head  <= head + ptag_t'(pop_n);
            tail  <= tail + ptag_t'(acc_1) + ptag_t'(acc_2);
            count <= count - cnt_t'(pop_n) + cnt_t'(acc_1) + cnt_t'(acc_2);
            if (ovf_1 || ovf_2) ovf_q <= 1'b1;
            if (acc_1) mem[tail] <= fl.fp_i_1;
            if (acc_2) mem[tail + ptag_t'(acc_1)] <= fl.fp_i_2;
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [NUM_PREGS-1:0] in_list;
    logic [NUM_PREGS-1:0] in_list_nxt;
    logic                 dup_q;

    // Membership is the registered bitmap; a tag popped this cycle still counts as present.
    assign dup_1 = nz_1 && in_list[fl.fp_i_1];
    assign dup_2 = nz_2 && (in_list[fl.fp_i_2] || (fl.rt_flag_1 && fl.fp_i_2 == fl.fp_i_1));
    assign fl.dup_err = dup_q;

    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        in_list_nxt = in_list;
        if (!stall && fl.alloc_req_1) in_list_nxt[fl.alloc_tag_1] = 1'b0;
        if (!stall && fl.alloc_req_2) in_list_nxt[fl.alloc_tag_2] = 1'b0;
        if (acc_1) in_list_nxt[fl.fp_i_1] = 1'b1;
        if (acc_2) in_list_nxt[fl.fp_i_2] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_q <= 1'b0;
            for (int i = 0; i < NUM_PREGS; i++) begin
                in_list[i] <= (i >= NUM_AREGS);
            end
        end else begin
            in_list <= in_list_nxt;
            if (dup_1 || dup_2) dup_q <= 1'b1;
        end
    end
`else
    assign dup_1      = 1'b0;
    assign dup_2      = 1'b0;
    assign fl.dup_err = 1'b0;
`endif
endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: a queue-based model of the free list is compared
// against the DUT every cycle, with directed scenarios plus a randomized alloc/free phase.
module tb_phys_free_list;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int PTAG_W    = 6;
`ifdef FREELIST_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    phys_free_list_if #(.PTAG_W(PTAG_W)) fl();

    phys_free_list #(
        .NUM_PREGS(NUM_PREGS),
        .NUM_AREGS(NUM_AREGS),
        .PTAG_W   (PTAG_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fl   (fl)
    );

    int checks = 0;
    int errors = 0;

    // Model: the free list is simply an ordered queue of tags; in-flight tags are those handed out.
    int m_q[$];
    int inflight[$];
    bit m_ovf;
    bit m_dup;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(input int t);
        foreach (m_q[i]) if (m_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        inflight.delete();
        for (int t = NUM_AREGS; t < NUM_PREGS; t++) m_q.push_back(t);
        m_ovf = 1'b0;
        m_dup = 1'b0;
    endtask

    task automatic model_step();
        int cnt;
        int need;
        int f1;
        int f2;
        int acc[$];
        cnt  = m_q.size();
        need = int'(fl.alloc_req_1) + int'(fl.alloc_req_2);
        f1   = int'(fl.fp_i_1);
        f2   = int'(fl.fp_i_2);
        if (fl.rt_flag_1 && f1 != 0) begin
            if (CHECK_EN && in_q(f1)) m_dup = 1'b1;
            else if (cnt < NUM_PREGS) begin acc.push_back(f1); cnt++; end
            else m_ovf = 1'b1;
        end
        if (fl.rt_flag_2 && f2 != 0) begin
            if (CHECK_EN && (in_q(f2) || (fl.rt_flag_1 && f2 == f1))) m_dup = 1'b1;
            else if (cnt < NUM_PREGS) begin acc.push_back(f2); cnt++; end
            else m_ovf = 1'b1;
        end
        if (need <= m_q.size()) repeat (need) inflight.push_back(m_q.pop_front());
        foreach (acc[i]) m_q.push_back(acc[i]);
    endtask

    always @(posedge clk) if (rst_n) model_step();

    // Compare process: outputs sampled mid-cycle against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            int  need;
            bit  st;
            need = int'(fl.alloc_req_1) + int'(fl.alloc_req_2);
            st   = need > m_q.size();
            check("alloc_stall", int'(fl.alloc_stall), int'(st));
            check("free_count", int'(fl.free_count), m_q.size());
            check("ovf_err", int'(fl.ovf_err), int'(m_ovf));
            check("dup_err", int'(fl.dup_err), int'(m_dup));
            if (!st && fl.alloc_req_1) check("alloc_tag_1", int'(fl.alloc_tag_1), m_q[0]);
            if (!st && fl.alloc_req_2)
                check("alloc_tag_2", int'(fl.alloc_tag_2), fl.alloc_req_1 ? m_q[1] : m_q[0]);
        end
    end

    task automatic drive(input bit r1, input bit r2, input bit v1, input int t1,
                         input bit v2, input int t2);
        fl.alloc_req_1 = r1;
        fl.alloc_req_2 = r2;
        fl.rt_flag_1   = v1;
        fl.fp_i_1      = PTAG_W'(t1);
        fl.rt_flag_2   = v2;
        fl.fp_i_2      = PTAG_W'(t2);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        idle();
        #1;
        check("reset_count", int'(fl.free_count), 32);
        check("reset_ovf", int'(fl.ovf_err), 0);
        check("reset_dup", int'(fl.dup_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic take_inflight(output bit ok, output int tag);
        int idx;
        ok  = 1'b0;
        tag = 0;
        if (inflight.size() > 0) begin
            idx = $urandom_range(0, inflight.size() - 1);
            tag = inflight[idx];
            inflight.delete(idx);
            ok = 1'b1;
        end
    endtask

    task automatic drain_all(input string name);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
            @(negedge clk);
            check({name, "_tag1"}, int'(fl.alloc_tag_1), 32 + 2 * k);
            check({name, "_tag2"}, int'(fl.alloc_tag_2), 33 + 2 * k);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #12;

        // First dual allocation from reset.
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        check("first_tag1", int'(fl.alloc_tag_1), 32);
        check("first_tag2", int'(fl.alloc_tag_2), 33);
        check("first_stall", int'(fl.alloc_stall), 0);
        tick();
        @(negedge clk);
        check("second_count", int'(fl.free_count), 30);
        check("second_tag1", int'(fl.alloc_tag_1), 34);
        check("second_tag2", int'(fl.alloc_tag_2), 35);
        tick();

        // Drain to empty, then stall on the 17th request.
        apply_reset();
        drain_all("drain");
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        check("empty_count", int'(fl.free_count), 0);
        check("empty_stall", int'(fl.alloc_stall), 1);
        tick();

        // A free is not visible to allocation in the same cycle.
        drive(1'b1, 1'b0, 1'b1, 40, 1'b0, 0);
        @(negedge clk);
        check("same_cycle_stall", int'(fl.alloc_stall), 1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        check("refill_stall", int'(fl.alloc_stall), 0);
        check("refill_tag1", int'(fl.alloc_tag_1), 40);
        tick();

        // One tag left: dual request stalls whole, single slot-2 request succeeds.
        drive(1'b0, 1'b0, 1'b1, 50, 1'b0, 0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        check("one_left_count", int'(fl.free_count), 1);
        check("one_left_stall", int'(fl.alloc_stall), 1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        check("one_left_count_kept", int'(fl.free_count), 1);
        check("slot2_only_tag", int'(fl.alloc_tag_2), 50);
        tick();
        idle();
        @(negedge clk);
        check("one_left_after", int'(fl.free_count), 0);
        tick();

        if (!CHECK_EN) begin
            // Fill to full; slot 2 of the last pair overflows.
            apply_reset();
            drive(1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
            tick();
            idle();
            @(negedge clk);
            check("tag0_dropped", int'(fl.free_count), 32);
            for (int k = 0; k < 15; k++) begin
                drive(1'b0, 1'b0, 1'b1, 2 * k + 1, 1'b1, 2 * k + 2);
                tick();
            end
            drive(1'b0, 1'b0, 1'b1, 31, 1'b0, 0);
            tick();
            drive(1'b0, 1'b0, 1'b1, 32, 1'b1, 33);
            tick();
            idle();
            @(negedge clk);
            check("full_count", int'(fl.free_count), 64);
            check("full_ovf", int'(fl.ovf_err), 1);
            drive(1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
            tick();
            idle();
            @(negedge clk);
            check("full_tag0_count", int'(fl.free_count), 64);
            tick();
        end else begin
            // Freeing a tag already in the list is dropped.
            apply_reset();
            drive(1'b0, 1'b0, 1'b1, 45, 1'b0, 0);
            tick();
            idle();
            @(negedge clk);
            check("dup_in_list_err", int'(fl.dup_err), 1);
            check("dup_in_list_count", int'(fl.free_count), 32);
            tick();
            // Same tag on both slots: only one copy enters the list.
            apply_reset();
            drive(1'b0, 1'b0, 1'b1, 7, 1'b1, 7);
            tick();
            idle();
            @(negedge clk);
            check("dup_pair_err", int'(fl.dup_err), 1);
            check("dup_pair_count", int'(fl.free_count), 33);
            tick();
            drain_all("dup_drain");
            drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
            @(negedge clk);
            check("dup_pair_tag", int'(fl.alloc_tag_1), 7);
            tick();
            idle();
            @(negedge clk);
            check("dup_pair_empty", int'(fl.free_count), 0);
            tick();
        end

        // Randomized traffic with a mid-run reset.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            bit r1;
            bit r2;
            bit v1;
            bit v2;
            int t1;
            int t2;
            if (c == 1500) apply_reset();
            r1 = ($urandom_range(0, 3) != 0);
            r2 = ($urandom_range(0, 3) != 0);
            v1 = 1'b0;
            v2 = 1'b0;
            t1 = 0;
            t2 = 0;
            if ($urandom_range(0, 31) == 0) begin
                v1 = 1'b1;
                t1 = $urandom_range(0, NUM_PREGS - 1);
            end else if ($urandom_range(0, 3) != 0) begin
                take_inflight(v1, t1);
            end
            if ($urandom_range(0, 31) == 0) begin
                v2 = 1'b1;
                t2 = $urandom_range(0, NUM_PREGS - 1);
            end else if ($urandom_range(0, 3) != 0) begin
                take_inflight(v2, t2);
            end
            drive(r1, r2, v1, t1, v2, t2);
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
